// File: rtl/mpmc10_chan_arbiter.sv
// mpmc10_chan_arbiter
// Round-robin arbiter that lends the single mpmc10 DRAM sequencer to one of
// NCHAN requesting channels. A grant lasts for one full pass of the sequencer,
// from leaving IDLE until returning to it. A grant the sequencer never takes up
// is withdrawn after ACK_TO cycles.
//
// Optional feature: define MPMC10_ARB_PRIO0_EN to give channel 0 (the video
// refresh channel) absolute priority. Serving channel 0 then leaves the
// round-robin pointer untouched. Without the macro, channel 0 is an ordinary
// round-robin participant.
//
// The sequencer state encoding comes from mpmc10_pkg. This file carries the
// one constant the arbiter depends on, the IDLE code.

package mpmc10_pkg;
    localparam logic [3:0] IDLE = 4'h0;
endpackage

module mpmc10_chan_arbiter #(
    parameter int NCHAN  = 8,
    parameter int CHW    = 3,
    parameter int ACK_TO = 15
) (
    input  logic             rst,
    input  logic             clk,
    input  logic [NCHAN-1:0] req,
    input  logic [3:0]       state,
    output logic [NCHAN-1:0] grant,
    output logic [CHW-1:0]   grant_num,
    output logic             grant_valid,
    output logic             start,
    output logic             done,
    output logic             timeout
);

    localparam int ACW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

    typedef enum logic [1:0] {
        A_IDLE,
        A_GRANT,
        A_BUSY,
        A_RETIRE
    } arb_state_t;

    arb_state_t       afsm, afsm_nx;
    logic [CHW-1:0]   last, last_nx;
    logic [ACW-1:0]   ackcnt, ackcnt_nx;

    logic [NCHAN-1:0] grant_nx;
    logic [CHW-1:0]   grant_num_nx;
    logic             grant_valid_nx;
    logic             start_nx;
    logic             done_nx;
    logic             timeout_nx;

    logic             seq_idle;
    logic             hi_found, lo_found;
    logic [CHW-1:0]   hi_num, lo_num;
    logic             pick_found;
    logic [CHW-1:0]   pick_num;
    logic [NCHAN-1:0] pick_oh;
    logic [CHW-1:0]   retire_last;

    assign seq_idle = (state == mpmc10_pkg::IDLE);

    // Round-robin pick: first request above the last served channel, else the
    // lowest request at or below it (which wraps the search modulo NCHAN).
    always_comb begin
        // NOTE: every combinational output is given a default up front so that no
        // path through the branches below leaves it unassigned and infers a latch.
        hi_found   = 1'b0;
        lo_found   = 1'b0;
        hi_num     = '0;
        lo_num     = '0;
        pick_oh    = '0;
        for (int j = 0; j < NCHAN; j++) begin
            if (req[j]) begin
                if (j > int'(last)) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_num   = CHW'(j);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_num   = CHW'(j);
                end
            end
        end
        pick_found = hi_found | lo_found;
        pick_num   = hi_found ? hi_num : lo_num;
`ifdef MPMC10_ARB_PRIO0_EN
        if (req[0]) begin
            pick_num = '0;
        end
`endif
        for (int j = 0; j < NCHAN; j++) begin
            pick_oh[j] = (CHW'(j) == pick_num);
        end
    end

    // Pointer value to store when the current grant ends (served or withdrawn).
    always_comb begin
`ifdef MPMC10_ARB_PRIO0_EN
        retire_last = (grant_num == '0) ? last : grant_num;
`else
        retire_last = grant_num;
`endif
    end

    // Next-state and next-output logic for the grant lifecycle.
    always_comb begin
        afsm_nx        = afsm;
        last_nx        = last;
        ackcnt_nx      = ackcnt;
        grant_nx       = grant;
        grant_num_nx   = grant_num;
        grant_valid_nx = grant_valid;
        start_nx       = 1'b0;
        done_nx        = 1'b0;
        timeout_nx     = 1'b0;
        unique case (afsm)
            A_IDLE: begin
                if (seq_idle && pick_found) begin
                    grant_nx       = pick_oh;
                    grant_num_nx   = pick_num;
                    grant_valid_nx = 1'b1;
                    start_nx       = 1'b1;
                    ackcnt_nx      = '0;
                    afsm_nx        = A_GRANT;
                end
            end
            A_GRANT: begin
                if (!seq_idle) begin
                    afsm_nx = A_BUSY;
                end else if (ackcnt == ACW'(ACK_TO - 1)) begin
                    // Withdrawn unaccepted: the channel still loses its turn.
                    grant_nx       = '0;
                    grant_num_nx   = '0;
                    grant_valid_nx = 1'b0;
                    timeout_nx     = 1'b1;
                    last_nx        = retire_last;
                    afsm_nx        = A_IDLE;
                end else begin
                    ackcnt_nx = ackcnt + ACW'(1);
                end
            end
            A_BUSY: begin
                if (seq_idle) begin
                    afsm_nx = A_RETIRE;
                end
            end
            A_RETIRE: begin
                grant_nx       = '0;
                grant_num_nx   = '0;
                grant_valid_nx = 1'b0;
                done_nx        = 1'b1;
                last_nx        = retire_last;
                afsm_nx        = A_IDLE;
            end
            default: begin
                afsm_nx = A_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            afsm        <= A_IDLE;
            last        <= CHW'(NCHAN - 1);
            ackcnt      <= '0;
            grant       <= '0;
            grant_num   <= '0;
            grant_valid <= 1'b0;
            start       <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            afsm        <= afsm_nx;
            last        <= last_nx;
            ackcnt      <= ackcnt_nx;
            grant       <= grant_nx;
            grant_num   <= grant_num_nx;
            grant_valid <= grant_valid_nx;
            start       <= start_nx;
            done        <= done_nx;
            timeout     <= timeout_nx;
        end
    end

endmodule
